t_flop_bank: RTL and testbench

//  Parametrised bank of WIDTH T flip-flops sharing one clock and reset.

---
 rtl/t_flop_bank.sv | 106 ++++++++++
 tb/tb_t_flop_bank.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/t_flop_bank.sv
// Bank of WIDTH T flip-flops: independent toggle register (MODE 0) or cascaded
// up/down T-flop counter with terminal-count pulse and saturating wrap count (MODE 1).

module t_flop_lane #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic load_bit,
  input  logic tog,
  output logic q,
  output logic toggled
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q       <= RST_BIT;
      toggled <= 1'b0;
    end else if (load) begin
      q       <= load_bit;
      toggled <= q ^ load_bit;
    end else begin
      q       <= q ^ tog;
      toggled <= tog;
    end
  end
endmodule

module t_flop_bank #(
  parameter int               WIDTH   = 8,
  parameter int               MODE    = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               WRAP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  t,
  input  logic              up,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  toggled,
  output logic              tc,
  output logic [WRAP_W-1:0] wrap_cnt
);
  // Reset asserts immediately, releases two edges after rst rises.
  logic [1:0] rst_sync;
  logic       rst_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i = rst_sync[1];

  logic [WIDTH-1:0] tog;
  logic             wrap;

  generate
    if (MODE == 0) begin : g_indep
      logic unused_up;
      assign unused_up = up;
      // Select rather than AND so an undefined t is fully masked while idle.
      assign tog  = en ? t : '0;
      assign wrap = 1'b0;
    end else begin : g_cnt
      logic             cnt_en;
      logic             unused_t;
      logic [WIDTH-1:0] ones_below, zeros_below;

      assign unused_t = ^t[WIDTH-1:1];
      assign cnt_en   = en & t[0];
      assign ones_below[0]  = 1'b1;
      assign zeros_below[0] = 1'b1;
      for (genvar i = 1; i < WIDTH; i++) begin : g_chain
        assign ones_below[i]  = ones_below[i-1]  &  q[i-1];
        assign zeros_below[i] = zeros_below[i-1] & ~q[i-1];
      end
      assign tog  = cnt_en ? (up ? ones_below : zeros_below) : '0;
      assign wrap = cnt_en & ~load & (up ? (&q) : ~(|q));
    end
  endgenerate

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    t_flop_lane #(.RST_BIT(RST_VAL[i])) u_lane (
      .clk      (clk),
      .rst      (rst_i),
      .load     (load),
      .load_bit (load_val[i]),
      .tog      (tog[i]),
      .q        (q[i]),
      .toggled  (toggled[i])
    );
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      tc       <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      tc <= wrap;
      if (wrap && (wrap_cnt != '1)) wrap_cnt <= wrap_cnt + WRAP_W'(1);
    end
  end
endmodule

// File: tb/tb_t_flop_bank.sv
// Randomized + directed bench for t_flop_bank: three configurations driven by one
// stimulus stream, each checked against an arithmetic reference model.

module tb_t_flop_bank;
  logic       clk = 1'b0;
  logic       rst, en, load, up;
  logic [7:0] load_val, t;

  logic [7:0] q0, tg0, q1, tg1;
  logic [1:0] q2, tg2, wc2;
  logic [3:0] wc0, wc1;
  logic       tc0, tc1, tc2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  t_flop_bank #(.WIDTH(8), .MODE(0), .RST_VAL(8'hA5), .WRAP_W(4)) u_tog (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .t(t), .up(up),
    .q(q0), .toggled(tg0), .tc(tc0), .wrap_cnt(wc0));

  t_flop_bank #(.WIDTH(8), .MODE(1), .RST_VAL(8'hA5), .WRAP_W(4)) u_cnt (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .t(t), .up(up),
    .q(q1), .toggled(tg1), .tc(tc1), .wrap_cnt(wc1));

  t_flop_bank #(.WIDTH(2), .MODE(1), .RST_VAL(2'b00), .WRAP_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val[1:0]), .t(t[1:0]), .up(up),
    .q(q2), .toggled(tg2), .tc(tc2), .wrap_cnt(wc2));

  // Reference model: per-configuration state, advanced with plain arithmetic.
  localparam int         K_MODE [3] = '{0, 1, 1};
  localparam logic [7:0] K_MASK [3] = '{8'hFF, 8'hFF, 8'h03};
  localparam logic [7:0] K_RST  [3] = '{8'hA5, 8'hA5, 8'h00};
  localparam int         K_WMAX [3] = '{15, 15, 3};

  logic [7:0] mq [3];
  logic [7:0] mtog [3];
  logic       mtc [3];
  int         mwc [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k] = K_RST[k]; mtog[k] = '0; mtc[k] = 1'b0; mwc[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      logic [7:0] m, nq;
      logic       w;
      m = K_MASK[k];
      if (load) begin
        nq = load_val & m; mtog[k] = mq[k] ^ nq; mtc[k] = 1'b0;
      end else if (en && K_MODE[k] == 0) begin
        nq = mq[k] ^ (t & m); mtog[k] = t & m; mtc[k] = 1'b0;
      end else if (en && t[0]) begin
        nq = up ? ((mq[k] + 8'd1) & m) : ((mq[k] - 8'd1) & m);
        w  = up ? (mq[k] == m) : (mq[k] == 8'd0);
        mtog[k] = mq[k] ^ nq; mtc[k] = w;
        if (w && mwc[k] < K_WMAX[k]) mwc[k]++;
      end else begin
        nq = mq[k]; mtog[k] = '0; mtc[k] = 1'b0;
      end
      mq[k] = nq;
    end
  endtask

  task automatic check_all();
    chk("q0", q0, mq[0]);   chk("tg0", tg0, mtog[0]); chk("tc0", tc0, mtc[0]); chk("wc0", wc0, mwc[0]);
    chk("q1", q1, mq[1]);   chk("tg1", tg1, mtog[1]); chk("tc1", tc1, mtc[1]); chk("wc1", wc1, mwc[1]);
    chk("q2", q2, mq[2]);   chk("tg2", tg2, mtog[2]); chk("tc2", tc2, mtc[2]); chk("wc2", wc2, mwc[2]);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    en = 1'b0; load = 1'b0; t = '0; load_val = '0; up = 1'b1;
  endtask

  // Assert reset mid-cycle with whatever inputs are active, check before the next edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 model_reset();
    check_all();
    idle();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) cyc();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b1;
    repeat (3) cyc();

    // Independent toggle
    load = 1'b1; load_val = 8'h00; cyc();
    load = 1'b0; en = 1'b1; t = 8'h0F; cyc();
    chk("t2_q_0f", q0, 8'h0F); chk("t2_tg_0f", tg0, 8'h0F);
    t = 8'hFF; cyc();
    chk("t2_q_f0", q0, 8'hF0);
    en = 1'b0; cyc();
    chk("t2_hold", q0, 8'hF0); chk("t2_tg0", tg0, 8'h00);

    // Up count through wrap
    do_reset();
    load = 1'b1; load_val = 8'hFE; up = 1'b1; cyc();
    load = 1'b0; en = 1'b1; t = 8'h01; cyc();
    chk("t3_ff", q1, 8'hFF); chk("t3_tc_a", tc1, 1'b0);
    cyc();
    chk("t3_00", q1, 8'h00); chk("t3_tc_b", tc1, 1'b1); chk("t3_tg", tg1, 8'hFF);
    cyc();
    chk("t3_01", q1, 8'h01); chk("t3_tc_c", tc1, 1'b0); chk("t3_wc", wc1, 4'd1);

    // Down through wrap, then direction flip
    do_reset();
    load = 1'b1; load_val = 8'h01; cyc();
    load = 1'b0; en = 1'b1; t = 8'h01; up = 1'b0; cyc();
    chk("t4_00", q1, 8'h00); chk("t4_tc_a", tc1, 1'b0);
    cyc();
    chk("t4_ff", q1, 8'hFF); chk("t4_tc_b", tc1, 1'b1);
    up = 1'b1; cyc();
    chk("t4_up00", q1, 8'h00); chk("t4_tc_c", tc1, 1'b1); chk("t4_wc", wc1, 4'd2);

    // Wrap counter saturation on the 2-bit bank
    do_reset();
    en = 1'b1; t = 8'h01; up = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (i == 11) chk("t5_wc11", wc2, 2'd2);
      if (i == 12) chk("t5_wc12", wc2, 2'd3);
    end
    chk("t5_wc20", wc2, 2'd3);

    // Load beats enable, then reset while counting
    load = 1'b1; en = 1'b1; t = 8'hFF; load_val = 8'h3C; cyc();
    chk("t6_q", q1, 8'h3C); chk("t6_tc", tc1, 1'b0);
    load = 1'b0; repeat (3) cyc();
    do_reset();

    // Undefined data while idle must not disturb state
    load = 1'b1; load_val = 8'h5A; cyc();
    load = 1'b0; en = 1'b0; t = 'x; load_val = 'x; repeat (2) cyc();
    chk("tx_q0", q0, 8'h5A); chk("tx_q1", q1, 8'h5A);
    idle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 15) == 0);
      t    = 8'($urandom);
      if ($urandom_range(0, 3) == 0) t[0] = 1'b0;
      up   = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 4))
        0:       load_val = 8'h00;
        1:       load_val = 8'hFF;
        2:       load_val = 8'hFE;
        3:       load_val = 8'h01;
        default: load_val = 8'($urandom);
      endcase
      if (i == 300) do_reset();
      else          cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
